pll_lock_ctrl: RTL

//  Sequences bring-up of the dynamic-loop-filter PLL (50 MHz in, 40 MHz out). Drives the PLL

---
 rtl/pll_ctrl_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 30 +++
 rtl/pll_lock_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and defaults for the PLL bring-up controller.
// Pure declarations; no latency and no handshake involved.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RST,
    WAIT,
    STABLE,
    LOCKED,
    FAIL
  } state_e;

  typedef struct packed {
    logic [5:0] icpsel;
    logic [2:0] lpfres;
    logic [1:0] lpfcap;
  } pll_setting_t;

  localparam int SETTING_W = 11;

  // Four loop settings, gentlest first; entry 0 occupies the LSBs.
  localparam logic [4*SETTING_W-1:0] DEFAULT_SETTINGS = {
    {6'h3f, 3'd7, 2'd3},
    {6'h1c, 3'd5, 2'd2},
    {6'h0e, 3'd3, 2'd1},
    {6'h06, 3'd1, 2'd0}
  };

  // Counter width for a count range of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Latency two clk_i cycles; no handshake, the level is simply sampled.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer: reset pulse, qualified lock wait, settings-table retry, relock.
// Lock decisions lag pll_lock_i by the two synchroniser cycles; no handshake on any port.
module pll_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int NUM_SETTINGS  = 4,
  parameter logic [NUM_SETTINGS*SETTING_W-1:0] SETTINGS =
      (NUM_SETTINGS*SETTING_W)'(DEFAULT_SETTINGS),
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             retry_i,
  input  logic             pll_lock_i,
  output logic             pll_reset_o,
  output logic [5:0]       icpsel_o,
  output logic [2:0]       lpfres_o,
  output logic [1:0]       lpfcap_o,
  output logic             locked_o,
  output logic             fail_o,
  output logic [3:0]       setting_idx_o,
  output logic [CNT_W-1:0] relock_cnt_o
);

  localparam int TMR_MAX = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int TMR_W   = cnt_w(TMR_MAX);
  localparam int STB_W   = cnt_w(STABLE_CYCLES);

  localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RESET_CYCLES - 1);
  localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_SETTINGS - 1);

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [STB_W-1:0]   stable_q, stable_d;
  logic [3:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   relock_q, relock_d;
  pll_setting_t       setting_q, setting_d;
  logic               lock_s;

  sync_2ff u_lock_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (pll_lock_i),
    .q_o    (lock_s)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= RST;
      timer_q   <= '0;
      stable_q  <= '0;
      idx_q     <= '0;
      relock_q  <= '0;
      setting_q <= pll_setting_t'(SETTINGS[SETTING_W-1:0]);
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      stable_q  <= stable_d;
      idx_q     <= idx_d;
      relock_q  <= relock_d;
      setting_q <= setting_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    stable_d  = stable_q;
    idx_d     = idx_q;
    relock_d  = relock_q;
    // Settings are reloaded only while the PLL is held in reset.
    setting_d = (state_q == RST) ?
                pll_setting_t'(SETTINGS[int'(idx_q)*SETTING_W +: SETTING_W]) : setting_q;
    case (state_q)
      RST: begin
        if (timer_q >= RST_LAST) begin
          state_d = WAIT;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WAIT: begin
        if (timer_q < TO_LAST) timer_d = timer_q + TMR_W'(1);
        if (lock_s) begin
          state_d  = STABLE;
          stable_d = '0;
        end else if (timer_q >= TO_LAST) begin
          timer_d = '0;
          if (idx_q < IDX_LAST) begin
            idx_d   = idx_q + 4'd1;
            state_d = RST;
          end else begin
            state_d = FAIL;
          end
        end
      end
      STABLE: begin
        // The lock-timeout budget keeps draining across lock glitches.
        if (timer_q < TO_LAST) timer_d = timer_q + TMR_W'(1);
        if (!lock_s) begin
          state_d = WAIT;
        end else if (stable_q >= STB_LAST) begin
          state_d = LOCKED;
        end else begin
          stable_d = stable_q + STB_W'(1);
        end
      end
      LOCKED: begin
        if (!lock_s) begin
          state_d = RST;
          timer_d = '0;
          if (relock_q != '1) relock_d = relock_q + CNT_W'(1);
        end
      end
      FAIL: begin
        if (retry_i) begin
          state_d = RST;
          timer_d = '0;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = RST;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    pll_reset_o   = (state_q == RST) || (state_q == FAIL);
    locked_o      = (state_q == LOCKED);
    fail_o        = (state_q == FAIL);
    setting_idx_o = idx_q;
    relock_cnt_o  = relock_q;
    icpsel_o      = setting_q.icpsel;
    lpfres_o      = setting_q.lpfres;
    lpfcap_o      = setting_q.lpfcap;
  end

endmodule
